// File: rtl/valve_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : valve_seq_pkg                                              |
// | Brief   : Shared state enum, valve levels and pump phase patterns    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package valve_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FILL     = 3'd1,
    ST_MIX      = 3'd2,
    ST_DISPENSE = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  localparam logic VALVE_OPEN   = 1'b0;
  localparam logic VALVE_CLOSED = 1'b1;

  localparam logic [2:0] PUMP_PH_A       = 3'b011;
  localparam logic [2:0] PUMP_PH_B       = 3'b101;
  localparam logic [2:0] PUMP_PH_C       = 3'b110;
  localparam logic [2:0] PUMP_ALL_OPEN   = 3'b000;
  localparam logic [2:0] PUMP_ALL_CLOSED = 3'b111;

  function automatic logic [2:0] pump_pattern(input logic [1:0] ph);
    case (ph)
      2'd0:    pump_pattern = PUMP_PH_A;
      2'd1:    pump_pattern = PUMP_PH_B;
      default: pump_pattern = PUMP_PH_C;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/valve_seq_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : valve_seq_ctrl_if                                          |
// | Brief   : Valid/ready command channel into the valve sequencer       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface valve_seq_ctrl_if #(
  parameter int LVL   = 2,
  parameter int ROT_W = 8
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LVL-1:0]   cmd_chan;
  logic [ROT_W-1:0] cmd_rot;

  modport master (output cmd_valid, cmd_chan, cmd_rot, input cmd_ready);
  modport slave  (input cmd_valid, cmd_chan, cmd_rot, output cmd_ready);
endinterface
`default_nettype wire

// File: rtl/pump_phase_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : pump_phase_gen                                             |
// | Brief   : Dwell counter and three-phase peristaltic pattern source   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pump_phase_gen
  import valve_seq_pkg::*;
#(
  parameter int PHASE_DWELL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       start,
  input  logic [2:0] park_pat,
  output logic [2:0] pump_v,
  output logic       rot_done
);

  localparam int DW_W = (PHASE_DWELL > 1) ? $clog2(PHASE_DWELL) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(PHASE_DWELL - 1);

  logic [1:0]      phase_q, phase_d;
  logic [DW_W-1:0] dwell_q, dwell_d;
  logic [2:0]      pump_q, pump_d;
  logic            phase_end;

  assign phase_end = (dwell_q == DWELL_LAST);
  // Depends on flops only, so the parent FSM can use it without a loop.
  assign rot_done  = phase_end && (phase_q == 2'd2);
  assign pump_v    = pump_q;

  always_comb begin
    phase_d = phase_q;
    dwell_d = dwell_q;
    pump_d  = pump_q;
    if (start) begin
      phase_d = 2'd0;
      dwell_d = '0;
      pump_d  = PUMP_PH_A;
    end else if (enable) begin
      if (phase_end) begin
        dwell_d = '0;
        phase_d = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
        pump_d  = pump_pattern(phase_d);
      end else begin
        dwell_d = dwell_q + 1'b1;
      end
    end else begin
      phase_d = 2'd0;
      dwell_d = '0;
      pump_d  = park_pat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 2'd0;
      dwell_q <= '0;
      pump_q  <= PUMP_ALL_CLOSED;
    end else begin
      phase_q <= phase_d;
      dwell_q <= dwell_d;
      pump_q  <= pump_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/valve_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : valve_seq_ctrl                                             |
// | Brief   : Fill / mix / dispense sequencer for mixer ring + mux tree. |
// |           VALVE_SEQ_ABORT_EN adds a synchronous abort input.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module valve_seq_ctrl
  import valve_seq_pkg::*;
#(
  parameter int N_CHAN      = 4,
  parameter int ROT_W       = 8,
  parameter int SETTLE      = 8,
  parameter int PHASE_DWELL = 4,
  parameter int FLUSH       = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
`ifdef VALVE_SEQ_ABORT_EN
  input  logic                          abort,
`endif
  valve_seq_ctrl_if.slave               cmd,
  output logic                          busy,
  output logic                          done,
  output logic                          inlet_v,
  output logic                          outlet_v,
  output logic [2:0]                    pump_v,
  output logic [2*$clog2(N_CHAN)-1:0]   mux_v
);

  localparam int LVL     = $clog2(N_CHAN);
  localparam int CNT_MAX = (SETTLE > FLUSH) ? SETTLE : FLUSH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST  = CNT_W'(FLUSH - 1);
  localparam logic [ROT_W-1:0] ROT_ONE     = ROT_W'(1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LVL-1:0]     chan_q, chan_d;
  logic [ROT_W-1:0]   rot_q, rot_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic               inlet_q, inlet_d;
  logic               outlet_q, outlet_d;
  logic [2*LVL-1:0]   mux_q, mux_d;
  logic [2*LVL-1:0]   mux_disp_w;
  logic               abort_w;
  logic               rot_done_w;
  logic               pump_start_w;
  logic               pump_en_w;
  logic [2:0]         pump_park_w;

`ifdef VALVE_SEQ_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // Level k opens the branch selected by chan bit k; pair = {bit=1 line, bit=0 line}.
  for (genvar k = 0; k < LVL; k++) begin : g_mux
    assign mux_disp_w[2*k+1] = chan_q[k] ? VALVE_OPEN   : VALVE_CLOSED;
    assign mux_disp_w[2*k]   = chan_q[k] ? VALVE_CLOSED : VALVE_OPEN;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    chan_d  = chan_q;
    rot_d   = rot_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd.cmd_valid && ready_q) begin
          chan_d  = cmd.cmd_chan;
          rot_d   = cmd.cmd_rot;
          cnt_d   = SETTLE_LAST;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (abort_w || (cnt_q == '0 && rot_q == '0)) begin
          state_d = ST_DISPENSE;
          cnt_d   = FLUSH_LAST;
        end else if (cnt_q == '0) begin
          state_d = ST_MIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_MIX: begin
        if (abort_w || (rot_done_w && rot_q == ROT_ONE)) begin
          state_d = ST_DISPENSE;
          cnt_d   = FLUSH_LAST;
        end else if (rot_done_w) begin
          rot_d = rot_q - 1'b1;
        end
      end
      ST_DISPENSE: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so every valve line is a flop.
    inlet_d  = (state_d == ST_FILL)     ? VALVE_OPEN : VALVE_CLOSED;
    outlet_d = (state_d == ST_DISPENSE) ? VALVE_OPEN : VALVE_CLOSED;
    mux_d    = (state_d == ST_DISPENSE) ? mux_disp_w : {(2*LVL){VALVE_CLOSED}};
    busy_d   = (state_d != ST_IDLE);
    ready_d  = (state_d == ST_IDLE);
    done_d   = (state_d == ST_DONE);
  end

  assign pump_start_w = (state_d == ST_MIX) && (state_q != ST_MIX);
  assign pump_en_w    = (state_d == ST_MIX) && (state_q == ST_MIX);
  assign pump_park_w  = ((state_d == ST_FILL) || (state_d == ST_DISPENSE)) ?
                        PUMP_ALL_OPEN : PUMP_ALL_CLOSED;

  pump_phase_gen #(
    .PHASE_DWELL (PHASE_DWELL)
  ) u_pump (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (pump_en_w),
    .start    (pump_start_w),
    .park_pat (pump_park_w),
    .pump_v   (pump_v),
    .rot_done (rot_done_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      chan_q   <= '0;
      rot_q    <= '0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      inlet_q  <= VALVE_CLOSED;
      outlet_q <= VALVE_CLOSED;
      mux_q    <= {(2*LVL){VALVE_CLOSED}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      chan_q   <= chan_d;
      rot_q    <= rot_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      inlet_q  <= inlet_d;
      outlet_q <= outlet_d;
      mux_q    <= mux_d;
    end
  end

  assign cmd.cmd_ready = ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign inlet_v       = inlet_q;
  assign outlet_v      = outlet_q;
  assign mux_v         = mux_q;

endmodule
`default_nettype wire

// File: tb/tb_valve_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_valve_seq_ctrl                                          |
// | Brief   : Self-checking bench for valve_seq_ctrl (two configurations)|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_valve_seq_ctrl;

  typedef struct packed {
    logic       inlet;
    logic       outlet;
    logic [2:0] pump;
    logic [5:0] mux;
    logic       busy;
    logic       done;
    logic       ready;
  } obs_t;

  typedef struct {
    int         chan;
    int         rot;
    int         exp_done;
    logic [5:0] exp_mux;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  valve_seq_ctrl_if #(.LVL(2), .ROT_W(8)) if0 ();
  valve_seq_ctrl_if #(.LVL(3), .ROT_W(2)) if8 ();

  logic       busy0, done0, inlet0, outlet0;
  logic [2:0] pump0;
  logic [3:0] mux0;
  logic       busy8, done8, inlet8, outlet8;
  logic [2:0] pump8;
  logic [5:0] mux8;
`ifdef VALVE_SEQ_ABORT_EN
  logic abort0 = 1'b0;
  logic abort8 = 1'b0;
`endif

  valve_seq_ctrl dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef VALVE_SEQ_ABORT_EN
    .abort    (abort0),
`endif
    .cmd      (if0),
    .busy     (busy0),
    .done     (done0),
    .inlet_v  (inlet0),
    .outlet_v (outlet0),
    .pump_v   (pump0),
    .mux_v    (mux0)
  );

  valve_seq_ctrl #(
    .N_CHAN(8), .ROT_W(2), .SETTLE(3), .PHASE_DWELL(2), .FLUSH(5)
  ) dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef VALVE_SEQ_ABORT_EN
    .abort    (abort8),
`endif
    .cmd      (if8),
    .busy     (busy8),
    .done     (done8),
    .inlet_v  (inlet8),
    .outlet_v (outlet8),
    .pump_v   (pump8),
    .mux_v    (mux8)
  );

  // Reference model: expected outputs in cycle t after acceptance (cycle 0).
  function automatic int disp_start(int rot, int abort_t, int settle, int pd);
    int nat;
    nat = settle + 3 * pd * rot + 1;
    if (abort_t >= 1 && abort_t < nat) return abort_t + 1;
    return nat;
  endfunction

  function automatic obs_t model(int t, int chan, int rot, int abort_t,
                                 int settle, int pd, int flush, int lvl);
    obs_t o;
    int ds, dc, m;
    ds = disp_start(rot, abort_t, settle, pd);
    dc = ds + flush;
    o.inlet = 1'b1; o.outlet = 1'b1; o.pump = 3'b111; o.mux = 6'b0;
    o.busy = 1'b1; o.done = 1'b0; o.ready = 1'b0;
    for (int k = 0; k < 2 * lvl; k++) o.mux[k] = 1'b1;
    if (t <= 0 || t > dc) begin
      o.busy = 1'b0; o.ready = 1'b1;
    end else if (t <= settle && t < ds) begin
      o.inlet = 1'b0; o.pump = 3'b000;
    end else if (t < ds) begin
      m = t - settle - 1;
      case ((m / pd) % 3)
        0:       o.pump = 3'b011;
        1:       o.pump = 3'b101;
        default: o.pump = 3'b110;
      endcase
    end else if (t < dc) begin
      o.outlet = 1'b0; o.pump = 3'b000;
      for (int k = 0; k < lvl; k++) begin
        o.mux[2*k+1] = ((chan >> k) & 1) ? 1'b0 : 1'b1;
        o.mux[2*k]   = ((chan >> k) & 1) ? 1'b1 : 1'b0;
      end
    end else begin
      o.done = 1'b1;
    end
    return o;
  endfunction

  function automatic obs_t actual(int which);
    obs_t o;
    if (which == 0) begin
      o.inlet = inlet0; o.outlet = outlet0; o.pump = pump0; o.mux = {2'b00, mux0};
      o.busy = busy0; o.done = done0; o.ready = if0.cmd_ready;
    end else begin
      o.inlet = inlet8; o.outlet = outlet8; o.pump = pump8; o.mux = mux8;
      o.busy = busy8; o.done = done8; o.ready = if8.cmd_ready;
    end
    return o;
  endfunction

  task automatic check_obs(string name, obs_t a, obs_t e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (in,out,pump,mux,busy,done,ready)", name, a, e);
    end
  endtask

  task automatic check_int(string name, int a, int e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, a, e);
    end
  endtask

  task automatic drive(int which, bit v, int chan, int rot);
    if (which == 0) begin
      if0.cmd_valid = v; if0.cmd_chan = chan[1:0]; if0.cmd_rot = rot[7:0];
    end else begin
      if8.cmd_valid = v; if8.cmd_chan = chan[2:0]; if8.cmd_rot = rot[1:0];
    end
  endtask

  // Issues one command at the current negedge and checks every cycle up to ready again.
  task automatic run_seq(input int which, input int chan, input int rot, input int abort_t,
                         input bit hold, input bit noise,
                         output int done_seen, output logic [5:0] mux_seen, output int acc_cyc);
    int settle, pd, flush, lvl, ds, dc;
    obs_t a, e;
    if (which == 0) begin settle = 8; pd = 4; flush = 16; lvl = 2; end
    else            begin settle = 3; pd = 2; flush = 5;  lvl = 3; end
    for (int i = 0; i < 100 && !actual(which).ready; i++) @(negedge clk);
    check_int($sformatf("ready_before_cmd d%0d", which), int'(actual(which).ready), 1);
    drive(which, 1'b1, chan, rot);
    acc_cyc   = cyc;
    ds        = disp_start(rot, abort_t, settle, pd);
    dc        = ds + flush;
    done_seen = -1;
    mux_seen  = '0;
    for (int t = 1; t <= dc + 1; t++) begin
      @(negedge clk);
      a = actual(which);
      e = model(t, chan, rot, abort_t, settle, pd, flush, lvl);
      check_obs($sformatf("trace d%0d ch%0d rot%0d t%0d", which, chan, rot, t), a, e);
      if (a.done && done_seen < 0) done_seen = t;
      if (t == ds) mux_seen = a.mux;
`ifdef VALVE_SEQ_ABORT_EN
      if (which == 0) abort0 = (t == abort_t);
`endif
      if (hold) drive(which, 1'b1, noise ? int'($urandom) : chan, noise ? int'($urandom) : rot);
      else if (t <= dc) drive(which, noise ? bit'($urandom % 2) : 1'b0,
                             noise ? int'($urandom) : chan, noise ? int'($urandom) : rot);
      else drive(which, 1'b0, chan, rot);
    end
  endtask

  vec_t       tbl[4];
  int         ds_r, acc1, acc2, gap, w, ch, rt;
  logic [5:0] ms_r;

  initial begin
    tbl[0] = '{chan: 2, rot: 3, exp_done: 61, exp_mux: 6'b000110};
    tbl[1] = '{chan: 0, rot: 0, exp_done: 25, exp_mux: 6'b001010};
    tbl[2] = '{chan: 3, rot: 1, exp_done: 37, exp_mux: 6'b000101};
    tbl[3] = '{chan: 1, rot: 2, exp_done: 49, exp_mux: 6'b001001};

    drive(0, 1'b0, 0, 0);
    drive(1, 1'b0, 0, 0);
    repeat (3) @(negedge clk);
    check_obs("reset_state d0", actual(0), model(0, 0, 0, -1, 8, 4, 16, 2));
    check_obs("reset_state d8", actual(1), model(0, 0, 0, -1, 3, 2, 5, 3));
    rst_n = 1'b1;
    @(negedge clk);
    check_obs("post_reset d0", actual(0), model(0, 0, 0, -1, 8, 4, 16, 2));

    foreach (tbl[i]) begin
      run_seq(0, tbl[i].chan, tbl[i].rot, -1, 1'b0, 1'b0, ds_r, ms_r, acc1);
      check_int($sformatf("done_cycle vec%0d", i), ds_r, tbl[i].exp_done);
      check_int($sformatf("dispense_mux vec%0d", i), int'(ms_r), int'(tbl[i].exp_mux));
    end

    // cmd_valid held high across a whole sequence: next acceptance one cycle after done.
    run_seq(0, 1, 1, -1, 1'b1, 1'b0, ds_r, ms_r, acc1);
    run_seq(0, 2, 0, -1, 1'b0, 1'b0, ds_r, ms_r, acc2);
    check_int("back_to_back_spacing", acc2 - acc1, 38);

    run_seq(1, 5, 3, -1, 1'b0, 1'b0, ds_r, ms_r, acc1);
    check_int("n8_done_cycle", ds_r, 27);
    check_int("n8_mux_decode", int'(ms_r), int'(6'b011001));

    run_seq(0, 3, 255, -1, 1'b0, 1'b0, ds_r, ms_r, acc1);
    check_int("max_rot_done_cycle", ds_r, 3085);

`ifdef VALVE_SEQ_ABORT_EN
    run_seq(0, 1, 3, 20, 1'b0, 1'b0, ds_r, ms_r, acc1);
    check_int("abort_done_cycle", ds_r, 37);
`endif

    for (int r = 0; r < 12; r++) begin
      w  = int'($urandom % 2);
      ch = int'($urandom % (w == 1 ? 8 : 4));
      rt = int'($urandom_range(0, 3));
      run_seq(w, ch, rt, -1, 1'b0, 1'b1, ds_r, ms_r, acc1);
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        check_obs($sformatf("idle_gap d%0d", w), actual(w), model(0, 0, 0, -1, 1, 1, 1, w == 1 ? 3 : 2));
      end
    end

    // Asynchronous reset in the middle of MIX.
    drive(0, 1'b1, 1, 3);
    @(negedge clk);
    drive(0, 1'b0, 1, 3);
    repeat (19) @(negedge clk);
    check_int("busy_mid_mix", int'(busy0), 1);
    #2 rst_n = 1'b0;
    #1 check_obs("async_reset_valves", actual(0), model(0, 0, 0, -1, 8, 4, 16, 2));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_obs($sformatf("after_reset_idle %0d", i), actual(0), model(0, 0, 0, -1, 8, 4, 16, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
